// File: rtl/fpnew_divsqrt_arbiter_pkg.sv
// Shared FP types for the div/sqrt arbiter slice.
// Mirrors the subset of fpnew types the arbiter touches.
package fpnew_divsqrt_arbiter_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    MUL  = 4'd1,
    DIV  = 4'd2,
    SQRT = 4'd3
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/fpnew_divsqrt_id_fifo.sv
// In-order FIFO of requester indices.
// Head is the owner of the next unit result.
module fpnew_divsqrt_id_fifo #(
  parameter int unsigned DataWidth = 1,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrW =
    (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntW-1:0]      count_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ?
      '0 : p + PtrW'(1);
  endfunction

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Round-robin share of one div/sqrt unit.
// Index FIFO steers in-order results home.
module fpnew_divsqrt_arbiter
  import fpnew_divsqrt_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned Width       = 64,
  parameter int unsigned MaxInFlight = 4,
  parameter type         TagType     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NumReq-1:0][1:0][Width-1:0]
               req_operands_i,
  input  roundmode_e [NumReq-1:0] req_rnd_mode_i,
  input  operation_e [NumReq-1:0] req_op_i,
  input  fp_format_e [NumReq-1:0] req_dst_fmt_i,
  input  TagType [NumReq-1:0]     req_tag_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [Width-1:0]        rsp_result_o,
  output status_t                 rsp_status_o,
  output TagType                  rsp_tag_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic [1:0][Width-1:0]   unit_operands_o,
  output roundmode_e              unit_rnd_mode_o,
  output operation_e              unit_op_o,
  output fp_format_e              unit_dst_fmt_o,
  output TagType                  unit_tag_o,
  output logic                    unit_in_valid_o,
  input  logic                    unit_in_ready_i,
  input  logic [Width-1:0]        unit_result_i,
  input  status_t                 unit_status_i,
  input  TagType                  unit_tag_i,
  input  logic                    unit_out_valid_i,
  output logic                    unit_out_ready_o,
  input  logic                    flush_i,
  output logic                    unit_flush_o,
  output logic                    busy_o
);

  localparam int unsigned IdxWidth =
    (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntWidth =
    $clog2(MaxInFlight + 1);

  logic [IdxWidth-1:0] rr_ptr_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                lock_q;
  logic [IdxWidth-1:0] grant;
  logic                handshake;
  logic [IdxWidth-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CntWidth-1:0] fifo_count;
  logic                pop;

  // pick first valid at/after rr_ptr unless locked
  always_comb begin
    logic                found;
    logic [IdxWidth-1:0] cand;
    grant = rr_ptr_q;
    found = 1'b0;
    cand  = '0;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        cand = IdxWidth'(
          (32'(rr_ptr_q) + i) % NumReq);
        if (!found && req_valid_i[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign unit_in_valid_o = ~rst_i
                         & req_valid_i[grant]
                         & ~fifo_full
                         & ~flush_i;
  assign handshake = unit_in_valid_o
                   & unit_in_ready_i;

  assign unit_operands_o = req_operands_i[grant];
  assign unit_rnd_mode_o = req_rnd_mode_i[grant];
  assign unit_op_o       = req_op_i[grant];
  assign unit_dst_fmt_o  = req_dst_fmt_i[grant];
  assign unit_tag_o      = req_tag_i[grant];
  assign unit_flush_o    = flush_i;

  // one-hot accept toward the granted requester
  always_comb begin
    req_ready_o = '0;
    if (handshake) req_ready_o[grant] = 1'b1;
  end

  // route result to FIFO head; drain if orphaned
  always_comb begin
    rsp_valid_o      = '0;
    unit_out_ready_o = 1'b1;
    if (!fifo_empty) begin
      unit_out_ready_o = rsp_ready_i[head];
      if (unit_out_valid_i && !flush_i && !rst_i)
        rsp_valid_o[head] = 1'b1;
    end
  end

  assign pop = unit_out_valid_i
             & unit_out_ready_o
             & ~fifo_empty
             & ~flush_i;

  assign rsp_result_o = unit_result_i;
  assign rsp_status_o = unit_status_i;
  assign rsp_tag_o    = unit_tag_i;

  assign busy_o = ~rst_i
                & (~fifo_empty | (|req_valid_i));

  // rr pointer and stall lock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (handshake) begin
      lock_q   <= 1'b0;
      rr_ptr_q <= (grant == IdxWidth'(NumReq - 1)) ?
        '0 : grant + IdxWidth'(1);
    end else if (unit_in_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end
  end

  fpnew_divsqrt_id_fifo #(
    .DataWidth (IdxWidth),
    .Depth     (MaxInFlight)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (handshake),
    .data_i  (grant),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_no_orphan_rsp: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(unit_out_valid_i && fifo_empty));

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    fifo_count <= CntWidth'(MaxInFlight));

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Random + directed bench for the div/sqrt arbiter.
// Queue-based model of grants and result routing.
module tb_fpnew_divsqrt_arbiter;
  import fpnew_divsqrt_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][1:0][63:0] req_operands;
  roundmode_e [1:0] req_rnd_mode;
  operation_e [1:0] req_op;
  fp_format_e [1:0] req_dst_fmt;
  logic [1:0] req_tag;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [63:0] rsp_result;
  status_t rsp_status;
  logic rsp_tag;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [1:0][63:0] unit_operands;
  roundmode_e unit_rnd_mode;
  operation_e unit_op;
  fp_format_e unit_dst_fmt;
  logic unit_tag;
  logic unit_in_valid;
  logic unit_in_ready;
  logic [63:0] unit_result;
  status_t unit_status;
  logic unit_tag_r;
  logic unit_out_valid;
  logic unit_out_ready;
  logic flush;
  logic unit_flush;
  logic busy;

  fpnew_divsqrt_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_operands_i   (req_operands),
    .req_rnd_mode_i   (req_rnd_mode),
    .req_op_i         (req_op),
    .req_dst_fmt_i    (req_dst_fmt),
    .req_tag_i        (req_tag),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .rsp_result_o     (rsp_result),
    .rsp_status_o     (rsp_status),
    .rsp_tag_o        (rsp_tag),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .unit_operands_o  (unit_operands),
    .unit_rnd_mode_o  (unit_rnd_mode),
    .unit_op_o        (unit_op),
    .unit_dst_fmt_o   (unit_dst_fmt),
    .unit_tag_o       (unit_tag),
    .unit_in_valid_o  (unit_in_valid),
    .unit_in_ready_i  (unit_in_ready),
    .unit_result_i    (unit_result),
    .unit_status_i    (unit_status),
    .unit_tag_i       (unit_tag_r),
    .unit_out_valid_i (unit_out_valid),
    .unit_out_ready_o (unit_out_ready),
    .flush_i          (flush),
    .unit_flush_o     (unit_flush),
    .busy_o           (busy)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic        tag;
  } uent_t;

  int errors = 0;
  int checks = 0;

  // stimulus knobs (percent)
  int p_req = 0;
  int p_ir  = 0;
  int p_ov  = 0;
  int p_rr  = 100;
  int p_fl  = 0;
  bit force_flush = 0;
  int drop = -1;

  // model state
  int    mq[$];
  uent_t uq[$];
  int    rr_m = 0;
  int    lock_m = -1;

  // last observed values for literal pins
  logic [1:0] obs_ready;
  logic [1:0] obs_rv;
  logic       obs_iv;
  logic       obs_busy;
  logic       obs_fl;

  task automatic chk(input string n,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  task automatic raise(input int i);
    req_valid[i] = 1'b1;
    req_operands[i][0] = {$urandom, $urandom};
    req_operands[i][1] = {$urandom, $urandom};
    req_op[i] = $urandom_range(1) ? DIV : SQRT;
    req_rnd_mode[i] =
      roundmode_e'(3'($urandom_range(4)));
    req_dst_fmt[i] =
      fp_format_e'(3'($urandom_range(4)));
    req_tag[i] = 1'($urandom_range(1));
  endtask

  function automatic uent_t unit_fn(input int i);
    uent_t e;
    if (req_op[i] == DIV)
      e.res = req_operands[i][0]
            ^ req_operands[i][1];
    else
      e.res = ~req_operands[i][0];
    e.st  = e.res[4:0];
    e.tag = req_tag[i];
    return e;
  endfunction

  task automatic step();
    int g;
    bit found;
    bit fl;
    bit exp_iv;
    bit exp_hs;
    bit exp_or;
    bit exp_pop;
    bit exp_busy;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    @(negedge clk);
    if (drop >= 0) begin
      req_valid[drop] = 1'b0;
      drop = -1;
    end
    if (!rst)
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] &&
            $urandom_range(99) < p_req)
          raise(i);
    unit_in_ready = ($urandom_range(99) < p_ir);
    for (int i = 0; i < 2; i++)
      rsp_ready[i] = ($urandom_range(99) < p_rr);
    fl = force_flush ||
         ($urandom_range(99) < p_fl);
    flush = fl;
    unit_out_valid = (uq.size() > 0) &&
                     ($urandom_range(99) < p_ov);
    if (unit_out_valid) begin
      unit_result = uq[0].res;
      unit_status = status_t'(uq[0].st);
      unit_tag_r  = uq[0].tag;
    end else begin
      unit_result = {$urandom, $urandom};
      unit_status = status_t'(5'($urandom));
      unit_tag_r  = 1'($urandom);
    end
    #1;
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_iv    = unit_in_valid;
    obs_busy  = busy;
    obs_fl    = unit_flush;
    if (rst) begin
      chk("rst_in_valid", unit_in_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      uq.delete();
      lock_m = -1;
      rr_m = 0;
    end else begin
      g = 0;
      found = 0;
      if (lock_m >= 0) begin
        g = lock_m;
        found = 1;
      end else begin
        for (int k = 0; k < 2; k++)
          if (!found && req_valid[(rr_m+k)%2]) begin
            g = (rr_m + k) % 2;
            found = 1;
          end
      end
      exp_iv = found && req_valid[g] &&
               (mq.size() < 4) && !fl;
      exp_hs = exp_iv && unit_in_ready;
      exp_ready = exp_hs ? 2'(1 << g) : 2'b00;
      exp_rv = 2'b00;
      exp_or = 1'b1;
      if (mq.size() > 0) begin
        exp_or = rsp_ready[mq[0]];
        if (unit_out_valid && !fl)
          exp_rv = 2'(1 << mq[0]);
      end
      exp_pop = (mq.size() > 0) &&
                unit_out_valid && exp_or && !fl;
      exp_busy = (mq.size() > 0) || (|req_valid);
      chk("in_valid", unit_in_valid, exp_iv);
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("out_ready", unit_out_ready, exp_or);
      chk("busy", busy, exp_busy);
      chk("unit_flush", unit_flush, fl);
      if (exp_iv) begin
        chk("unit_operands", unit_operands,
            req_operands[g]);
        chk("unit_fields",
            {unit_rnd_mode, unit_op,
             unit_dst_fmt, unit_tag},
            {req_rnd_mode[g], req_op[g],
             req_dst_fmt[g], req_tag[g]});
      end
      if (exp_rv != 0) begin
        chk("rsp_result", rsp_result, uq[0].res);
        chk("rsp_status_tag",
            {rsp_status, rsp_tag},
            {uq[0].st, uq[0].tag});
      end
      if (fl) begin
        mq.delete();
        uq.delete();
        lock_m = -1;
      end else begin
        if (exp_pop) begin
          void'(mq.pop_front());
          void'(uq.pop_front());
        end
        if (exp_hs) begin
          mq.push_back(g);
          uq.push_back(unit_fn(g));
          rr_m = (g + 1) % 2;
          lock_m = -1;
          drop = g;
        end else if (exp_iv) begin
          lock_m = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    unit_in_ready = 1'b0;
    unit_out_valid = 1'b0;
    rsp_ready = 2'b00;
    unit_result = '0;
    unit_status = '0;
    unit_tag_r = 1'b0;
    req_valid = 2'b00;
    req_operands = '0;
    req_rnd_mode = {RNE, RNE};
    req_op = {DIV, DIV};
    req_dst_fmt = {FP64, FP64};
    req_tag = 2'b00;

    // reset with both requesting
    raise(0);
    raise(1);
    p_ir = 100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_no_valid", obs_iv, 0);
      chk("reset_no_ready", obs_ready, 0);
    end
    rst = 1'b0;

    // fairness: 0,1,0,1 and routed results
    p_req = 100; p_ov = 100; p_rr = 100;
    step();
    chk("fair_g0", obs_ready, 2'b01);
    chk("fair_r0", obs_rv, 2'b00);
    step();
    chk("fair_g1", obs_ready, 2'b10);
    chk("fair_r1", obs_rv, 2'b01);
    step();
    chk("fair_g2", obs_ready, 2'b01);
    chk("fair_r2", obs_rv, 2'b10);
    step();
    chk("fair_g3", obs_ready, 2'b10);
    chk("fair_r3", obs_rv, 2'b01);

    // drain to idle
    p_req = 0;
    for (int c = 0; c < 8; c++) step();
    chk("idle_busy", obs_busy, 0);

    // lock: req0 stalls, req1 shows up later
    p_ir = 0;
    raise(0);
    step();
    raise(1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("lock_stall", obs_ready, 2'b00);
    end
    p_ir = 100;
    step();
    chk("lock_g0", obs_ready, 2'b01);
    step();
    chk("lock_g1", obs_ready, 2'b10);
    for (int c = 0; c < 5; c++) step();

    // full FIFO: four dispatches then stall
    p_req = 100; p_ov = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("full_dispatch", obs_ready != 0, 1);
    end
    step();
    chk("full_block_rdy", obs_ready, 2'b00);
    chk("full_block_iv", obs_iv, 0);
    p_ov = 100;
    step();
    chk("full_pop_rdy", obs_ready, 2'b00);
    chk("full_pop_rsp", obs_rv != 0, 1);
    p_ov = 0;
    step();
    chk("full_resume", obs_ready != 0, 1);

    // flush with results waiting
    force_flush = 1; p_ov = 100;
    step();
    chk("flush_rsp", obs_rv, 2'b00);
    chk("flush_fwd", obs_fl, 1);
    chk("flush_rdy", obs_ready, 2'b00);
    force_flush = 0; p_ov = 0;
    step();
    chk("post_flush", obs_ready != 0, 1);

    // random traffic
    p_req = 40; p_ir = 70; p_ov = 60;
    p_rr = 70; p_fl = 1;
    for (int c = 0; c < 3000; c++) step();

    // drain
    p_req = 0; p_ir = 100; p_ov = 100;
    p_rr = 100; p_fl = 0;
    for (int c = 0; c < 30; c++) step();
    chk("final_busy", obs_busy, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
